// File: rtl/score_digit_reader.sv
// Streams a snapshotted packed-BCD score one digit per valid/ready handshake, MSD first, with blank/last flags.
// SCORE_READER_HISCORE_EN builds the high-score register and the new_high pulse; otherwise both outputs are tied to 0.
module score_digit_reader #(
  parameter int DIGITS = 4,
  localparam int IW = $clog2(DIGITS)
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic [DIGITS*4-1:0]   score,
  input  logic                  start,
  output logic                  digit_valid,
  input  logic                  digit_ready,
  output logic [3:0]            digit,
  output logic [IW-1:0]         digit_idx,
  output logic                  digit_blank,
  output logic                  digit_last,
  output logic                  busy,
  output logic                  done,
  output logic                  bcd_err,
  output logic [DIGITS*4-1:0]   hi_score,
  output logic                  new_high
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                  state;
  logic [DIGITS-1:0][3:0]  shadow;
  logic [DIGITS-1:0][3:0]  score_d;
  logic [IW-1:0]           idx;
  logic                    done_r;
  logic                    err_r;
  logic                    snap_err;
  logic                    accept;
  logic [DIGITS-1:0]       zero_above;

  assign score_d = score;
  assign accept  = (state == IDLE) && start;

  always_comb begin
    snap_err = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (score_d[i] > 4'd9) snap_err = 1'b1;
    end
  end

  // zero_above[i]: shadow digits i..DIGITS-1 are all zero
  always_comb begin
    logic z;
    z          = 1'b1;
    zero_above = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      z             = z & (shadow[i] == 4'd0);
      zero_above[i] = z;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state  <= IDLE;
      shadow <= '0;
      idx    <= '0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shadow <= score_d;
            idx    <= IW'(DIGITS - 1);
            err_r  <= snap_err;
            state  <= SEND;
          end
        end
        SEND: begin
          if (digit_ready) begin
            if (idx == '0) begin
              state  <= IDLE;
              done_r <= 1'b1;
            end else begin
              idx <= idx - IW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy        = (state == SEND);
  assign digit_valid = busy;
  assign digit       = busy ? shadow[idx] : 4'd0;
  assign digit_idx   = busy ? idx : '0;
  assign digit_last  = busy && (idx == '0);
  // Digit 0 is never blanked so a zero score still renders as "0"
  assign digit_blank = busy && (idx != '0) && zero_above[idx];
  assign done        = done_r;
  assign bcd_err     = err_r;

`ifdef SCORE_READER_HISCORE_EN
  logic [DIGITS*4-1:0] hi_r;
  logic                nh_r;

  // Raw binary compare matches BCD magnitude order; snapshots with bad digits never qualify
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hi_r <= '0;
      nh_r <= 1'b0;
    end else begin
      nh_r <= 1'b0;
      if (accept && !snap_err && (score > hi_r)) begin
        hi_r <= score;
        nh_r <= 1'b1;
      end
    end
  end

  assign hi_score = hi_r;
  assign new_high = nh_r;
`else
  assign hi_score = '0;
  assign new_high = 1'b0;
`endif

endmodule

// File: tb/tb_score_digit_reader.sv
// Directed, table-driven bench for score_digit_reader (DIGITS=4); also exercises hi-score when its macro is defined.
module tb_score_digit_reader;

`ifdef SCORE_READER_HISCORE_EN
  localparam bit HI = 1'b1;
`else
  localparam bit HI = 1'b0;
`endif

  logic        clk;
  logic        resetN;
  logic [15:0] score;
  logic        start;
  logic        digit_valid;
  logic        digit_ready;
  logic [3:0]  digit;
  logic [1:0]  digit_idx;
  logic        digit_blank;
  logic        digit_last;
  logic        busy;
  logic        done;
  logic        bcd_err;
  logic [15:0] hi_score;
  logic        new_high;

  int n_cmp = 0;
  int n_bad = 0;

  score_digit_reader #(.DIGITS(4)) dut (
    .clk(clk), .resetN(resetN), .score(score), .start(start),
    .digit_valid(digit_valid), .digit_ready(digit_ready), .digit(digit),
    .digit_idx(digit_idx), .digit_blank(digit_blank), .digit_last(digit_last),
    .busy(busy), .done(done), .bcd_err(bcd_err), .hi_score(hi_score),
    .new_high(new_high)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] score;
    logic [3:0]  blank;   // expected blank per idx, bit k = idx k
    logic        err;
    logic        nh;      // expected new_high (with hi-score built)
    logic [15:0] hi;      // expected hi_score after this start
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  // Start a stream with ready held high and check every beat plus the done pulse
  task automatic run_stream(input logic [15:0] s, input logic [3:0] bl, input logic err,
                            input logic nh, input logic [15:0] hi);
    @(negedge clk);
    score = s; start = 1'b1; digit_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("new_high", new_high, HI ? nh : 1'b0);
    chk("hi_score", hi_score, HI ? hi : 16'h0);
    chk("bcd_err", bcd_err, err);
    for (int k = 3; k >= 0; k--) begin
      chk("valid", digit_valid, 1'b1);
      chk("busy", busy, 1'b1);
      chk("digit", digit, s[k*4 +: 4]);
      chk("idx", digit_idx, k);
      chk("blank", digit_blank, bl[k]);
      chk("last", digit_last, k == 0);
      chk("done_early", done, 1'b0);
      if (k == 2) chk("new_high_width", new_high, 1'b0);
      @(negedge clk);
    end
    chk("done", done, 1'b1);
    chk("valid_end", digit_valid, 1'b0);
    chk("busy_end", busy, 1'b0);
    @(negedge clk);
    chk("done_width", done, 1'b0);
  endtask

  initial begin
    int dones;
    vecs[0] = '{16'h0120, 4'b1000, 1'b0, 1'b1, 16'h0120};
    vecs[1] = '{16'h0099, 4'b1100, 1'b0, 1'b0, 16'h0120};
    vecs[2] = '{16'h0120, 4'b1000, 1'b0, 1'b0, 16'h0120};
    vecs[3] = '{16'h0121, 4'b1000, 1'b0, 1'b1, 16'h0121};
    vecs[4] = '{16'h0A50, 4'b1000, 1'b1, 1'b0, 16'h0121};
    vecs[5] = '{16'h0305, 4'b1000, 1'b0, 1'b1, 16'h0305};
    vecs[6] = '{16'h0000, 4'b1110, 1'b0, 1'b0, 16'h0305};
    vecs[7] = '{16'h1000, 4'b0000, 1'b0, 1'b1, 16'h1000};
    vecs[8] = '{16'h0007, 4'b1110, 1'b0, 1'b0, 16'h1000};
    vecs[9] = '{16'hF000, 4'b0000, 1'b1, 1'b0, 16'h1000};

    resetN = 1'b0; score = 16'h0; start = 1'b0; digit_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", digit_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", bcd_err, 1'b0);
    chk("rst_last", digit_last, 1'b0);
    chk("rst_blank", digit_blank, 1'b0);
    chk("rst_digit", digit, 4'h0);
    chk("rst_idx", digit_idx, 2'd0);
    chk("rst_hi", hi_score, 16'h0);
    chk("rst_nh", new_high, 1'b0);
    resetN = 1'b1;

    for (int v = 0; v < 10; v++)
      run_stream(vecs[v].score, vecs[v].blank, vecs[v].err, vecs[v].nh, vecs[v].hi);

    // Backpressure: hold ready low for 3 cycles while idx 2 is presented
    @(negedge clk);
    score = 16'h0305; start = 1'b1; digit_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("bp_idx3", digit_idx, 2'd3);
    @(negedge clk);
    digit_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_hold_valid", digit_valid, 1'b1);
      chk("bp_hold_digit", digit, 4'h3);
      chk("bp_hold_idx", digit_idx, 2'd2);
      chk("bp_hold_blank", digit_blank, 1'b0);
    end
    digit_ready = 1'b1;
    @(negedge clk);
    chk("bp_idx1", digit_idx, 2'd1);
    chk("bp_digit1", digit, 4'h0);
    @(negedge clk);
    chk("bp_idx0", digit_idx, 2'd0);
    chk("bp_digit0", digit, 4'h5);
    chk("bp_last", digit_last, 1'b1);
    @(negedge clk);
    chk("bp_done", done, 1'b1);
    chk("bp_valid_end", digit_valid, 1'b0);

    // start during SEND with a changing score is ignored
    @(negedge clk);
    score = 16'h0305; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("ign_idx2", digit_idx, 2'd2);
    score = 16'h9999; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ign_digit1", digit, 4'h0);
    @(negedge clk);
    chk("ign_digit0", digit, 4'h5);
    dones = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done) dones++;
      if (c > 0) chk("ign_no_restart", digit_valid, 1'b0);
    end
    chk("ign_done_count", dones, 1);
    chk("ign_err", bcd_err, 1'b0);

    // Asynchronous reset mid-stream
    @(negedge clk);
    score = 16'h0305; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_idx1", digit_idx, 2'd1);
    #1 resetN = 1'b0;
    #1;
    chk("rst_mid_valid", digit_valid, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    @(negedge clk);
    resetN = 1'b1;
    dones = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("rst_mid_no_done", dones, 0);
    chk("rst_mid_hi", hi_score, 16'h0);
    run_stream(16'h0305, 4'b1000, 1'b0, 1'b1, 16'h0305);

    // start accepted in the same cycle done is high
    @(negedge clk);
    score = 16'h0042; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("b2b_last", digit_last, 1'b1);
    @(negedge clk);
    chk("b2b_done", done, 1'b1);
    score = 16'h0007; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_valid", digit_valid, 1'b1);
    chk("b2b_idx", digit_idx, 2'd3);
    chk("b2b_blank", digit_blank, 1'b1);
    repeat (3) @(negedge clk);
    chk("b2b_digit0", digit, 4'h7);
    @(negedge clk);
    chk("b2b_done2", done, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

endmodule
